// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer feeding a 2-entry fetch queue with redirect/flush and halt.
module fetch_sequencer #(
    parameter int WORD_LEN  = 32,
    parameter int MEM_DEPTH = 32,
    parameter int RESET_PC  = 0,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    output logic [AW-1:0]       imem_addr,
    input  logic [WORD_LEN-1:0] imem_data,
    input  logic                redirect_valid,
    input  logic [AW-1:0]       redirect_pc,
    input  logic                halt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] out_instr,
    output logic [AW-1:0]       out_pc,
    output logic                halted
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, pc0_q, pc0_d, pc1_q, pc1_d;
    logic [WORD_LEN-1:0] in0_q, in0_d, in1_q, in1_d;
    logic [1:0] cnt_q, cnt_d;
    logic pop, push, slot1;
    assign pop = cnt_q != 2'd0 && out_ready;
    assign push = state_q == RUN && !halt && !redirect_valid && (cnt_q != 2'd2 || pop);
    assign slot1 = cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop);
    assign out_valid = cnt_q != 2'd0;
    assign out_pc = out_valid ? pc0_q : '0;
    assign out_instr = out_valid ? in0_q : '0;
    assign halted = state_q == HALTED;
    assign imem_addr = pc_q;
    always_comb begin
        state_d = halt ? HALTED : RUN;
        pc_d = pc_q;
        cnt_d = cnt_q;
        pc0_d = pc0_q;
        in0_d = in0_q;
        pc1_d = pc1_q;
        in1_d = in1_q;
        if (redirect_valid) begin
            cnt_d = 2'd0;
            pc_d = redirect_pc;
        end else begin
            if (pop) begin
                pc0_d = pc1_q;
                in0_d = in1_q;
            end
            if (push) begin
                pc_d = pc_q + AW'(1);
                if (slot1) begin
                    pc1_d = pc_q;
                    in1_d = imem_data;
                end else begin
                    pc0_d = pc_q;
                    in0_d = imem_data;
                end
            end
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q <= AW'(RESET_PC);
            cnt_q <= 2'd0;
            pc0_q <= '0;
            in0_q <= '0;
            pc1_q <= '0;
            in1_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            cnt_q <= cnt_d;
            pc0_q <= pc0_d;
            in0_q <= in0_d;
            pc1_q <= pc1_d;
            in1_q <= in1_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random stimulus checked against a queue-based model.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, redirect_valid, halt, out_ready, out_valid, halted;
    logic [4:0] imem_addr, redirect_pc, out_pc;
    logic [31:0] imem_data, out_instr;
    logic [31:0] mem [32];
    assign imem_data = mem[imem_addr];
    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] instr;
    } ent_t;
    ent_t q[$];
    logic [4:0] pc_m;
    logic halted_m;
    int passed = 0, total = 0;
    fetch_sequencer dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic cyc(input logic r, input logic rv, input logic [4:0] rp, input logic h, input logic rd);
        bit pop;
        int n;
        reset = r;
        redirect_valid = rv;
        redirect_pc = rp;
        halt = h;
        out_ready = rd;
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        check("out_pc", {27'd0, out_pc}, q.size() != 0 ? {27'd0, q[0].pc} : 32'd0);
        check("out_instr", out_instr, q.size() != 0 ? q[0].instr : 32'd0);
        check("halted", {31'd0, halted}, {31'd0, halted_m});
        check("imem_addr", {27'd0, imem_addr}, {27'd0, pc_m});
        @(posedge clk);
        n = q.size();
        pop = n != 0 && rd;
        if (r) begin
            q.delete();
            pc_m = 5'd0;
            halted_m = 1'b0;
        end else begin
            if (rv) begin
                q.delete();
                pc_m = rp;
            end else begin
                if (pop) void'(q.pop_front());
                if (!halted_m && !h && (n < 2 || pop)) begin
                    q.push_back(ent_t'{pc_m, mem[pc_m]});
                    pc_m++;
                end
            end
            halted_m = h;
        end
        #1;
    endtask
    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'(k + 100);
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 5'd0;
        halt = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        q.delete();
        pc_m = 5'd0;
        halted_m = 1'b0;
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_pc", {27'd0, out_pc}, 32'd0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        check("stall_addr", {27'd0, imem_addr}, 32'd2);
        check("stall_head", {27'd0, out_pc}, 32'd0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 5'd20, 0, 0);
        check("redir_gap", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 5'd30, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_empty", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 5'd17, 1, 1);
        check("rst_redir_valid", {31'd0, out_valid}, 32'd0);
        check("rst_redir_addr", {27'd0, imem_addr}, 32'd0);
        check("rst_redir_halted", {31'd0, halted}, 32'd0);
        for (int k = 0; k < 32; k++) mem[k] = $urandom;
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, 5'($urandom),
                $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
